booth_seq_mult: RTL and testbench
=================================

Name: booth_seq_mult

Overview:
- Sequential radix-2 Booth signed multiplier; the stage directly downstream of the N-bit operand registers.
- Consumes the registered multiplicand A and multiplier B.
- Produces a registered 2N-bit signed product after N iteration cycles, with a START/DONE handshake.
- Its output feeds the product register and display path of the signed multiplier datapath.

Parameters:
- N, 4, operand width in bits (two's complement); N >= 2.

Ports:
- CLK  input  1  rising-edge clock; sole clock.
- CLR  input  1  reset, synchronous, active-high.
- START  input  1  request; sampled on the rising CLK edge when BUSY=0.
- A  input  N  signed multiplicand, from the operand register.
- B  input  N  signed multiplier, from the operand register.
- P  output  2N  signed product, registered; holds its value until the next completion.
- DONE  output  1  one-cycle pulse; P is valid and newly updated.
- BUSY  output  1  high while an operation is in progress.

Behaviour:
- Reset: reset is synchronous and active-high. CLR=1 at a rising CLK edge sets P=0, DONE=0, BUSY=0, state=IDLE, and clears all internal registers.
- CLR has priority over every other event, including START and an in-flight operation.
- If CLR is asserted mid-operation, the operation is aborted, no DONE pulse is produced, and P=0.
- Internal registers:
  - M: N+1 bits, sign-extended A.
  - ACC: N+1 bits.
  - Q: N bits.
  - Q_1: 1 bit.
  - CNT: ceil(log2(N+1)) bits.
- ACC is N+1 bits so that subtracting M = -2^(N-1) cannot overflow.
- States: IDLE, RUN.
- IDLE:
  - BUSY=0.
  - If START=1 at an edge: M <= sext(A); Q <= B; ACC <= 0; Q_1 <= 0; CNT <= N; go to RUN.
  - A and B are sampled only at that edge; later changes on A and B are ignored until the next accepted START.
- RUN (one iteration per edge), with BUSY=1:
  - Select on {Q[0], Q_1}:
    - 01: T = ACC + M.
    - 10: T = ACC - M.
    - 00 or 11: T = ACC.
  - Arithmetic right shift of {T, Q, Q_1} by 1, replicating the MSB of T.
  - CNT <= CNT - 1.
  - On the edge where CNT=1 (the Nth iteration):
    - P <= the low 2N bits of {shifted ACC, shifted Q}.
    - DONE <= 1.
    - State returns to IDLE.
- Latency: with START accepted at edge k, the iterations run on edges k+1 to k+N. P and DONE update at edge k+N, so DONE is high for the single cycle following edge k+N.
- DONE is 0 in every other cycle.
- START while BUSY=1 is ignored. It is neither queued nor allowed to corrupt the operands.
- START=1 during the cycle in which DONE=1 is accepted, because the state is already IDLE. This gives back-to-back operations every N+1 cycles.
- P retains the last result across IDLE periods and across ignored STARTs.
- Result range: the full signed range is exact, including (-2^(N-1)) x (-2^(N-1)) = +2^(2N-2).

Test Plan:
- Reset, then hold START=0 for 10 cycles -> P=8'h00, DONE=0, BUSY=0 throughout.
- A=3, B=5, pulse START -> BUSY high for 4 cycles; DONE pulses once, exactly 4 cycles after the START edge; P=8'h0F (15).
- Sign cases, each started separately:
  - A=-3 (4'hD), B=5 -> P=8'hF1.
  - A=-8, B=7 -> P=8'hC8 (-56).
  - A=-8, B=-8 -> P=8'h40 (+64).
  - A=0, B=-1 -> P=8'h00.
- A=2, B=6, START; change A and B to 4'hF and hold START=1 for the whole operation -> P=8'h0C. Then, with START still high in the DONE cycle, a second operation with A=B=4'hF starts immediately -> P=8'h01 at N+1 cycles after the first DONE.
- A=7, B=7, START; assert CLR for 1 cycle on the 2nd RUN cycle -> P=8'h00, BUSY=0, no DONE pulse; the next START with A=7, B=7 -> P=8'h31.
- Exhaustive sweep: all 256 (A,B) pairs back-to-back -> P equals the signed reference product every time; exactly one DONE per START; no DONE without a START.

Source files
------------

// File: rtl/booth_seq_mult.sv
// booth_seq_mult: sequential radix-2 Booth signed multiplier.
// Accepts a START request while idle, latches the two's complement operands and
// retires one Booth iteration per clock. After N iterations the 2N-bit product
// is registered on P and DONE pulses for one cycle.
//
// Ports:
//   CLK   rising-edge clock
//   CLR   synchronous active-high reset, highest priority (aborts an operation)
//   START request, accepted on a rising edge while BUSY=0
//   A     signed multiplicand (N bits)
//   B     signed multiplier (N bits)
//   P     registered signed product (2N bits), held until the next completion
//   DONE  one-cycle pulse when P has just been updated
//   BUSY  high while an operation is in progress
module booth_seq_mult #(
   parameter int unsigned N = 4
) (
   input  logic           CLK,
   input  logic           CLR,
   input  logic           START,
   input  logic [N-1:0]   A,
   input  logic [N-1:0]   B,
   output logic [2*N-1:0] P,
   output logic           DONE,
   output logic           BUSY
);

   localparam int unsigned CW = $clog2(N + 1);

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   state_e           state_q, state_d;
   logic [N:0]       m_q, m_d;
   logic [N:0]       acc_q, acc_d;
   logic [N-1:0]     q_q, q_d;
   logic             q1_q, q1_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [2*N-1:0]   p_q, p_d;
   logic             done_q, done_d;

   // One Booth step: add/subtract M, then arithmetic shift of {T, Q, Q_1}.
   // ACC carries one guard bit so that subtracting M = -2^(N-1) stays exact.
   logic [N:0]   t;
   logic [N:0]   acc_sh;
   logic [N-1:0] q_sh;

   always_comb begin
      t = acc_q;
      unique case ({q_q[0], q1_q})
         2'b01:   t = acc_q + m_q;
         2'b10:   t = acc_q - m_q;
         default: t = acc_q;
      endcase
      acc_sh = {t[N], t[N:1]};
      q_sh   = {t[0], q_q[N-1:1]};
   end

   always_comb begin
      state_d = state_q;
      m_d     = m_q;
      acc_d   = acc_q;
      q_d     = q_q;
      q1_d    = q1_q;
      cnt_d   = cnt_q;
      p_d     = p_q;
      done_d  = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (START) begin
               m_d     = {A[N-1], A};
               q_d     = B;
               acc_d   = '0;
               q1_d    = 1'b0;
               cnt_d   = CW'(N);
               state_d = StRun;
            end
         end
         StRun: begin
            acc_d = acc_sh;
            q_d   = q_sh;
            q1_d  = q_q[0];
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               // Low 2N bits of the shifted {ACC, Q}; the guard bit is dropped.
               p_d     = {acc_sh[N-1:0], q_sh};
               done_d  = 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (CLR) begin
         state_q <= StIdle;
         m_q     <= '0;
         acc_q   <= '0;
         q_q     <= '0;
         q1_q    <= 1'b0;
         cnt_q   <= '0;
         p_q     <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         m_q     <= m_d;
         acc_q   <= acc_d;
         q_q     <= q_d;
         q1_q    <= q1_d;
         cnt_q   <= cnt_d;
         p_q     <= p_d;
         done_q  <= done_d;
      end
   end

   assign P    = p_q;
   assign DONE = done_q;
   assign BUSY = (state_q == StRun);

endmodule

// File: tb/tb_booth_seq_mult.sv
module tb_booth_seq_mult;

   localparam int N = 4;

   logic           CLK = 1'b0;
   logic           CLR = 1'b0;
   logic           START = 1'b0;
   logic [N-1:0]   A = '0;
   logic [N-1:0]   B = '0;
   logic [2*N-1:0] P;
   logic           DONE;
   logic           BUSY;

   booth_seq_mult #(.N(N)) dut (
      .CLK   (CLK),
      .CLR   (CLR),
      .START (START),
      .A     (A),
      .B     (B),
      .P     (P),
      .DONE  (DONE),
      .BUSY  (BUSY)
   );

   always #5 CLK = ~CLK;

   int passed = 0;
   int total  = 0;

   // Counters of DONE pulses and accepted STARTs, sampled mid-cycle.
   int done_cnt  = 0;
   int start_cnt = 0;
   always @(negedge CLK) begin
      if (DONE) done_cnt++;
      if (START && !BUSY && !CLR) start_cnt++;
   end

   typedef struct {
      logic [N-1:0]   a;
      logic [N-1:0]   b;
      logic [2*N-1:0] p;
      string          name;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Launch one operation from an idle (or DONE) cycle and wait for its DONE.
   task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [2*N-1:0] exp, input string name);
      int lat = 0;
      int busy_cnt = 0;
      A = a;
      B = b;
      START = 1'b1;
      step();
      START = 1'b0;
      for (int i = 1; i <= N + 4; i++) begin
         if (BUSY) busy_cnt++;
         step();
         if (DONE) begin
            lat = i;
            break;
         end
      end
      check({name, "_latency"}, lat, N);
      check({name, "_busy"}, busy_cnt, N);
      check({name, "_p"}, {24'h0, P}, {24'h0, exp});
      check({name, "_idle"}, {31'h0, BUSY}, 32'h0);
   endtask

   initial begin
      int bad;
      int d0, s0;
      logic [2*N-1:0] exp_p;

      vecs.push_back('{4'd3, 4'd5, 8'h0F, "3x5"});
      vecs.push_back('{4'hD, 4'd5, 8'hF1, "m3x5"});
      vecs.push_back('{4'h8, 4'd7, 8'hC8, "m8x7"});
      vecs.push_back('{4'h8, 4'h8, 8'h40, "m8xm8"});
      vecs.push_back('{4'h0, 4'hF, 8'h00, "0xm1"});
      vecs.push_back('{4'd7, 4'h8, 8'hC8, "7xm8"});
      vecs.push_back('{4'hF, 4'd1, 8'hFF, "m1x1"});
      vecs.push_back('{4'd1, 4'h8, 8'hF8, "1xm8"});
      vecs.push_back('{4'hF, 4'hF, 8'h01, "m1xm1"});
      vecs.push_back('{4'd7, 4'd7, 8'h31, "7x7"});

      // Reset and quiet idle period.
      CLR = 1'b1;
      step();
      CLR = 1'b0;
      check("reset_p", {24'h0, P}, 32'h0);
      check("reset_done", {31'h0, DONE}, 32'h0);
      check("reset_busy", {31'h0, BUSY}, 32'h0);
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (P !== 8'h00 || DONE !== 1'b0 || BUSY !== 1'b0) bad++;
      end
      check("idle_quiet", bad, 0);

      // Directed table; each op followed by a gap to confirm single pulse and P hold.
      foreach (vecs[i]) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].name);
         step();
         check({vecs[i].name, "_single_pulse"}, {31'h0, DONE}, 32'h0);
         check({vecs[i].name, "_hold"}, {24'h0, P}, {24'h0, vecs[i].p});
      end

      // Operands change and START stays high during the run; back-to-back restart.
      A = 4'd2;
      B = 4'd6;
      START = 1'b1;
      step();
      A = 4'hF;
      B = 4'hF;
      bad = 1;
      for (int i = 1; i <= N + 4; i++) begin
         step();
         if (DONE) begin
            check("hold_start_latency", i, N);
            bad = 0;
            break;
         end
      end
      check("hold_start_timeout", bad, 0);
      check("hold_start_p", {24'h0, P}, 32'h0C);
      bad = 1;
      for (int i = 1; i <= N + 5; i++) begin
         step();
         if (i == 1) START = 1'b0;
         if (DONE) begin
            check("b2b_latency", i, N + 1);
            bad = 0;
            break;
         end
      end
      check("b2b_timeout", bad, 0);
      check("b2b_p", {24'h0, P}, 32'h01);

      // CLR during the second RUN cycle aborts the operation.
      step();
      A = 4'd7;
      B = 4'd7;
      START = 1'b1;
      step();
      START = 1'b0;
      step();
      CLR = 1'b1;
      step();
      CLR = 1'b0;
      check("abort_p", {24'h0, P}, 32'h0);
      check("abort_busy", {31'h0, BUSY}, 32'h0);
      check("abort_done", {31'h0, DONE}, 32'h0);
      bad = 0;
      for (int i = 0; i < N + 2; i++) begin
         step();
         if (DONE !== 1'b0 || BUSY !== 1'b0 || P !== 8'h00) bad++;
      end
      check("abort_quiet", bad, 0);
      run_op(4'd7, 4'd7, 8'h31, "after_abort");

      // Exhaustive back-to-back sweep against the signed reference product.
      step();
      d0 = done_cnt;
      s0 = start_cnt;
      for (int ia = 0; ia < 16; ia++) begin
         for (int ib = 0; ib < 16; ib++) begin
            logic signed [N-1:0] sa, sb;
            int prod;
            sa = ia[N-1:0];
            sb = ib[N-1:0];
            prod = int'(sa) * int'(sb);
            exp_p = prod[2*N-1:0];
            run_op(sa, sb, exp_p, $sformatf("sweep_%0d_%0d", ia, ib));
         end
      end
      for (int i = 0; i < N + 2; i++) step();
      check("sweep_done_count", done_cnt - d0, 256);
      check("sweep_start_count", start_cnt - s0, 256);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish, got %0d/%0d checks", passed, total);
      $fatal(1);
   end

endmodule
